// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and constants for the clock divider bank
package clkdiv_pkg;

    localparam int MAX_CH    = 8;
    localparam int MAX_DIV_W = 32;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    // Fields are zero-extended from DIV_W so one struct serves every instance width.
    typedef struct packed {
        logic [MAX_DIV_W-1:0] div;
        logic [MAX_DIV_W-1:0] high;
        logic [MAX_DIV_W-1:0] phase;
    } chan_cfg_t;

    function automatic chan_cfg_t default_cfg(input logic [MAX_DIV_W-1:0] div);
        chan_cfg_t c;
        c.div   = div;
        c.high  = div >> 1;
        c.phase = '0;
        return c;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - configuration and output bundle of the clock divider bank
interface clkdiv_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 16
);

    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_high;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_apply;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] tick;
    logic              locked;

    modport master (
        output cfg_wr, cfg_ch, cfg_div, cfg_high, cfg_phase, cfg_apply,
        input  outclk, tick, locked
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_div, cfg_high, cfg_phase, cfg_apply,
        output outclk, tick, locked
    );

endinterface

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: period counter, active config, output flops
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DEF_DIV = 1
) (
    input  logic      refclk,
    input  logic      rst,
    input  logic      apply,
    input  chan_cfg_t shadow,
    input  logic      run,
    output logic      outclk,
    output logic      tick
);

    localparam logic [MAX_DIV_W-1:0] RST_DIV  = MAX_DIV_W'(DEF_DIV);
    localparam logic [MAX_DIV_W-1:0] RST_HIGH = RST_DIV >> 1;

    logic [MAX_DIV_W-1:0] div_q, div_d;
    logic [MAX_DIV_W-1:0] high_q, high_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [MAX_DIV_W-1:0] cnt_ext;
    logic                 out_d;
    logic                 tick_d;

    always_comb begin
        div_d   = div_q;
        high_d  = high_q;
        cnt_d   = cnt_q;
        cnt_ext = MAX_DIV_W'(cnt_q);
        if (apply) begin
            div_d  = shadow.div;
            high_d = shadow.high;
            cnt_d  = (shadow.phase < shadow.div) ? shadow.phase[DIV_W-1:0] : '0;
        end else if (div_q == '0 || cnt_ext >= div_q - MAX_DIV_W'(1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Outputs are registered from next-state values so they line up with cnt_q.
    always_comb begin
        out_d  = 1'b0;
        tick_d = 1'b0;
        if (run && div_d != '0) begin
            out_d  = MAX_DIV_W'(cnt_d) < high_d;
            tick_d = cnt_d == '0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            div_q  <= RST_DIV;
            high_q <= RST_HIGH;
            cnt_q  <= '0;
            outclk <= 1'b0;
            tick   <= 1'b0;
        end else begin
            div_q  <= div_d;
            high_q <= high_d;
            cnt_q  <= cnt_d;
            outclk <= out_d;
            tick   <= tick_d;
        end
    end

endmodule

// File: rtl/clkdiv_bank.sv
// rtl/clkdiv_bank.sv - bank of programmable clock dividers with shadow config and lock FSM
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH        = 3,
    parameter int                      DIV_W         = 16,
    parameter int                      SETTLE_CYCLES = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV       = {NUM_CH{DIV_W'(1)}}
) (
    input logic      refclk,
    input logic      rst,
    clkdiv_if.slave  bus
);

    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    if (NUM_CH < 1 || NUM_CH > MAX_CH || DIV_W < 1 || DIV_W > MAX_DIV_W
        || SETTLE_CYCLES < 1) begin : g_bad_param
        $error("clkdiv_bank: parameter out of range");
    end

    chan_cfg_t         shadow_q [NUM_CH];
    chan_cfg_t         wr_cfg;
    state_t            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              run;
    logic [NUM_CH-1:0] outclk_w;
    logic [NUM_CH-1:0] tick_w;

    assign wr_cfg = '{div:   MAX_DIV_W'(bus.cfg_div),
                      high:  MAX_DIV_W'(bus.cfg_high),
                      phase: MAX_DIV_W'(bus.cfg_phase)};

    // Channels read shadow_q on the apply edge, so a same-cycle write waits for the next apply.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= default_cfg(MAX_DIV_W'(DEF_DIV[i*DIV_W +: DIV_W]));
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_wr && bus.cfg_ch == 3'(i)) begin
                    shadow_q[i] <= wr_cfg;
                end
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RST;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Leaving RST counts as the first settle edge, so lock lands SETTLE_CYCLES edges after release.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_RST: begin
                state_d  = ST_SETTLE;
                settle_d = bus.cfg_apply ? '0 : SW'(1);
            end
            ST_SETTLE: begin
                if (bus.cfg_apply) begin
                    settle_d = '0;
                end else if (settle_q >= SW'(SETTLE_CYCLES - 1)) begin
                    state_d  = ST_LOCK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_LOCK: begin
                if (bus.cfg_apply) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = ST_RST;
                settle_d = '0;
            end
        endcase
    end

    assign run = (state_d == ST_LOCK);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clkdiv_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV[g*DIV_W +: DIV_W])
        ) u_chan (
            .refclk (refclk),
            .rst    (rst),
            .apply  (bus.cfg_apply),
            .shadow (shadow_q[g]),
            .run    (run),
            .outclk (outclk_w[g]),
            .tick   (tick_w[g])
        );
    end

    assign bus.outclk = outclk_w;
    assign bus.tick   = tick_w;
    assign bus.locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb/tb_clkdiv_bank.sv - self-checking bench for clkdiv_bank
module tb_clkdiv_bank;

    localparam int NCH    = 3;
    localparam int DW     = 16;
    localparam int SETTLE = 16;

    typedef struct {
        int   ch;
        int   div;
        int   high;
        int   phase;
        int   offset;
        logic exp_out;
        logic exp_tick;
        logic exp_lock;
    } vec_t;

    logic refclk = 1'b0;
    logic rst;
    always #5 refclk = ~refclk;

    clkdiv_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

    clkdiv_bank #(
        .NUM_CH        (NCH),
        .DIV_W         (DW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: each channel's count is (start + edges since apply) mod div.
    int n;
    int lock_edge;
    int sh_div [NCH];
    int sh_high [NCH];
    int sh_phase [NCH];
    int ac_div [NCH];
    int ac_high [NCH];
    int ac_start [NCH];
    int ac_base [NCH];

    vec_t tbl [14];

    task automatic check_bits(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        lock_edge = SETTLE;
        for (int i = 0; i < NCH; i++) begin
            sh_div[i] = 1; sh_high[i] = 0; sh_phase[i] = 0;
            ac_div[i] = 1; ac_high[i] = 0; ac_start[i] = 0; ac_base[i] = 0;
        end
    endtask

    task automatic check_model();
        logic [NCH-1:0] eo;
        logic [NCH-1:0] et;
        logic el;
        int c;
        el = !rst && n >= lock_edge;
        eo = '0;
        et = '0;
        for (int i = 0; i < NCH; i++) begin
            if (el && ac_div[i] != 0) begin
                c = (ac_start[i] + n - ac_base[i]) % ac_div[i];
                eo[i] = c < ac_high[i];
                et[i] = c == 0;
            end
        end
        check_bits("model_outclk", 8'(bus.outclk), 8'(eo));
        check_bits("model_tick", 8'(bus.tick), 8'(et));
        check_bits("model_locked", 8'(bus.locked), 8'(el));
    endtask

    task automatic step(input logic wr, input int ch, input int d, input int h, input int p,
                        input logic ap);
        bus.cfg_wr    = wr;
        bus.cfg_ch    = 3'(ch);
        bus.cfg_div   = DW'(d);
        bus.cfg_high  = DW'(h);
        bus.cfg_phase = DW'(p);
        bus.cfg_apply = ap;
        @(posedge refclk);
        if (!rst) begin
            n++;
            if (ap) begin
                for (int i = 0; i < NCH; i++) begin
                    ac_div[i]   = sh_div[i];
                    ac_high[i]  = sh_high[i];
                    ac_start[i] = (sh_phase[i] < sh_div[i]) ? sh_phase[i] : 0;
                    ac_base[i]  = n;
                end
                lock_edge = n + SETTLE;
            end
            if (wr && ch < NCH) begin
                sh_div[ch] = d; sh_high[ch] = h; sh_phase[ch] = p;
            end
        end
        #1 check_model();
        @(negedge refclk);
        bus.cfg_wr    = 1'b0;
        bus.cfg_apply = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        tbl = '{
            '{2, 50, 25, 0, 15, 1'b0, 1'b0, 1'b0},
            '{2, 50, 25, 0, 16, 1'b1, 1'b0, 1'b1},
            '{2, 50, 25, 0, 50, 1'b1, 1'b1, 1'b1},
            '{2, 50, 25, 0, 74, 1'b1, 1'b0, 1'b1},
            '{2, 50, 25, 0, 75, 1'b0, 1'b0, 1'b1},
            '{0,  0,  3, 0, 20, 1'b0, 1'b0, 1'b1},
            '{1,  5,  7, 0, 17, 1'b1, 1'b0, 1'b1},
            '{1,  5,  7, 0, 20, 1'b1, 1'b1, 1'b1},
            '{0,  5,  2, 9, 20, 1'b1, 1'b1, 1'b1},
            '{0,  5,  2, 9, 18, 1'b0, 1'b0, 1'b1},
            '{1,  1,  0, 0, 16, 1'b0, 1'b1, 1'b1},
            '{2,  4,  2, 3, 17, 1'b1, 1'b1, 1'b1},
            '{2,  4,  2, 3, 19, 1'b0, 1'b0, 1'b1},
            '{0,  5,  0, 0, 20, 1'b0, 1'b1, 1'b1}
        };

        rst = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        bus.cfg_high = '0; bus.cfg_phase = '0; bus.cfg_apply = 1'b0;
        model_reset();
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check_bits("reset_outclk", 8'(bus.outclk), 8'h00);
        check_bits("reset_tick", 8'(bus.tick), 8'h00);
        check_bits("reset_locked", 8'(bus.locked), 8'h00);
        rst = 1'b0;
        model_reset();

        // Defaults: locked rises on edge 16, every channel ticks each cycle.
        idle(15);
        check_bits("boot_locked_e15", 8'(bus.locked), 8'h00);
        idle(1);
        check_bits("boot_locked_e16", 8'(bus.locked), 8'h01);
        check_bits("boot_tick", 8'(bus.tick), 8'h07);
        check_bits("boot_outclk", 8'(bus.outclk), 8'h00);
        idle(3);
        check_bits("boot_tick_run", 8'(bus.tick), 8'h07);

        for (int v = 0; v < 14; v++) begin
            step(1'b1, tbl[v].ch, tbl[v].div, tbl[v].high, tbl[v].phase, 1'b0);
            step(1'b0, 0, 0, 0, 0, 1'b1);
            idle(tbl[v].offset);
            check_bits($sformatf("tbl%0d_out", v), 8'(bus.outclk[tbl[v].ch[1:0]]), 8'(tbl[v].exp_out));
            check_bits($sformatf("tbl%0d_tick", v), 8'(bus.tick[tbl[v].ch[1:0]]), 8'(tbl[v].exp_tick));
            check_bits($sformatf("tbl%0d_lock", v), 8'(bus.locked), 8'(tbl[v].exp_lock));
        end

        // Quadrature pair: ch1 offset by half a period is the inverse of ch0.
        step(1'b1, 0, 4, 2, 0, 1'b0);
        step(1'b1, 1, 4, 2, 2, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1);
        idle(16);
        for (int k = 0; k < 8; k++) begin
            check_bits("quad_pair", 8'(bus.outclk[1:0]), (k % 4 < 2) ? 8'h01 : 8'h02);
            idle(1);
        end

        // Write and apply together: old shadow applied, new one waits.
        step(1'b1, 0, 6, 3, 0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1);
        step(1'b1, 0, 8, 1, 0, 1'b1);
        idle(18);
        check_bits("wr_apply_old_tick", 8'(bus.tick[0]), 8'h01);
        check_bits("wr_apply_old_out", 8'(bus.outclk[0]), 8'h01);
        step(1'b0, 0, 0, 0, 0, 1'b1);
        idle(4);
        step(1'b0, 0, 0, 0, 0, 1'b1);
        idle(15);
        check_bits("reapply_locked_e15", 8'(bus.locked), 8'h00);
        idle(1);
        check_bits("reapply_locked_e16", 8'(bus.locked), 8'h01);
        check_bits("new_cfg_tick", 8'(bus.tick[0]), 8'h01);
        check_bits("new_cfg_out", 8'(bus.outclk[0]), 8'h01);
        idle(1);
        check_bits("new_cfg_out_low", 8'(bus.outclk[0]), 8'h00);

        // Asynchronous reset mid-lock, then defaults restored.
        step(1'b1, 1, 1, 0, 0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1);
        idle(17);
        check_bits("prepulse_tick1", 8'(bus.tick[1]), 8'h01);
        #1 rst = 1'b1;
        #1;
        check_bits("async_outclk", 8'(bus.outclk), 8'h00);
        check_bits("async_tick", 8'(bus.tick), 8'h00);
        check_bits("async_locked", 8'(bus.locked), 8'h00);
        model_reset();
        @(negedge refclk);
        idle(2);
        rst = 1'b0;
        idle(16);
        check_bits("restore_tick", 8'(bus.tick), 8'h07);
        check_bits("restore_outclk", 8'(bus.outclk), 8'h00);
        check_bits("restore_locked", 8'(bus.locked), 8'h01);

        // Randomised traffic against the model.
        for (int r = 0; r < 3000; r++) begin
            step(($urandom % 4) == 0, int'($urandom % 4), int'($urandom % 10),
                 int'($urandom % 11), int'($urandom % 12), ($urandom % 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 3, giving the number of divided output channels (legal range 1..8).
REQ-002 The block SHALL take parameter DIV_W, default 16, giving the width of the divisor, high-time and phase fields.
REQ-003 The block SHALL take parameter SETTLE_CYCLES, default 16, giving the number of refclk cycles from reset release or apply until locked asserts (legal range >=1).
REQ-004 The block SHALL take parameter DEF_DIV, packed NUM_CH*DIV_W, default 1 per channel, as the active divisor at reset; the reset high-time SHALL be DEF_DIV>>1 and the reset phase 0.
REQ-005 refclk  in  1  the single clock; all flops on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 cfg_wr  in  1  single-cycle write strobe into the shadow configuration.
REQ-008 cfg_ch  in  3  channel index for cfg_wr; values >= NUM_CH SHALL be ignored.
REQ-009 cfg_div  in  DIV_W  divisor (period in refclk cycles); 0 disables the channel.
REQ-010 cfg_high  in  DIV_W  number of high cycles per period.
REQ-011 cfg_phase  in  DIV_W  counter start value at apply.
REQ-012 cfg_apply  in  1  single-cycle strobe that copies the shadow to active for all channels at once.
REQ-013 outclk  out  NUM_CH  registered divided square waves, one bit per channel.
REQ-014 tick  out  NUM_CH  registered one-cycle enable marking the start of each period.
REQ-015 locked  out  1  high when all outputs run from a stable configuration.

Function
REQ-016 Each channel SHALL hold a counter cnt that steps 0..div-1 and wraps to 0, advancing once per refclk cycle.
REQ-017 outclk[i] SHALL be 1 in exactly those cycles where cnt_i < high_i; tick[i] SHALL be 1 in exactly those cycles where cnt_i == 0; both SHALL be flop outputs with no combinational path from the inputs.
REQ-018 When high_i >= div_i, outclk[i] SHALL be constant 1. When high_i == 0, outclk[i] SHALL be constant 0 and tick[i] SHALL keep running.
REQ-019 When div_i == 1, tick[i] SHALL be 1 every cycle. When div_i == 0, outclk[i] and tick[i] SHALL both be 0.
REQ-020 A cfg_wr SHALL update only the shadow entry for cfg_ch and SHALL NOT change the running outputs.
REQ-021 On the edge that samples cfg_apply, all active configurations SHALL load from the shadow as it stood before that edge. A cfg_wr in the same cycle SHALL land in the shadow for the next apply only.
REQ-022 On the same apply edge, each cnt_i SHALL load phase_i if phase_i < div_i, and 0 otherwise.
REQ-023 The control FSM SHALL have three states:
- RST: entered by reset; goes to SETTLE on the first edge after rst falls.
- SETTLE: settle counter runs; goes to LOCK after SETTLE_CYCLES cycles.
- LOCK: normal running; a cfg_apply returns it to SETTLE and restarts the settle counter.
REQ-024 locked SHALL be 1 only in LOCK. It SHALL fall on the apply edge and rise SETTLE_CYCLES edges later.
REQ-025 While locked is 0, outclk and tick SHALL be forced to 0. Channel counters SHALL keep running, so the phase relation between channels holds at lock.
REQ-026 A cfg_apply received during SETTLE SHALL reload the configuration and restart the settle count.

Reset
REQ-027 While rst is high:
- outclk = 0, tick = 0, locked = 0, all cnt = 0, FSM = RST;
- shadow and active configurations = DEF_DIV / DEF_DIV>>1 / phase 0.
REQ-028 rst asserted mid-operation SHALL take effect immediately, with no extra clock cycles, and SHALL discard any pending shadow writes.

Structure
REQ-029 Package clkdiv_pkg SHALL hold the FSM state enum, the MAX_CH=8 constant and the channel configuration struct (div, high, phase).
REQ-030 Sub-module clkdiv_chan SHALL implement one channel (counter, output flops, load on apply). clkdiv_bank SHALL instantiate NUM_CH copies of clkdiv_chan and own the shadow registers and the FSM.

Verification
REQ-031 Reset release with defaults (all div=1) -> locked rises on edge 16; tick = 3'b111 every cycle thereafter; outclk = 0 (high=0).
REQ-032 Write ch2 div=50 high=25 phase=0, then apply -> locked low for 16 cycles; then tick[2] every 50 cycles and outclk[2] 25 cycles high / 25 cycles low.
REQ-033 ch0 div=4 high=2 phase=0, ch1 div=4 high=2 phase=2, apply together -> outclk[1] is exactly the inverse of outclk[0] after lock.
REQ-034 Boundary values -> div=0 gives constant-0 outputs; high=7 with div=5 gives constant-1 outclk; phase=9 with div=5 starts the counter at 0.
REQ-035 cfg_wr and cfg_apply in the same cycle -> the old shadow is applied and the new value takes effect only at the next apply; a second apply during SETTLE restarts the 16-cycle count.
REQ-036 rst pulsed mid-LOCK -> all outputs drop to 0 asynchronously and the DEF_DIV configuration is restored.
